// File: rtl/instruction_sequencer_if.sv
// Host/downstream signal bundle for instruction_sequencer: program load
// handshake, run control and the registered instruction bus.
interface instruction_sequencer_if #(
  parameter int INSTR_W = 88,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6
);
  logic               load_valid;
  logic               load_ready;
  logic [INSTR_W-1:0] load_data;
  logic               clear;
  logic               start;
  logic               stall;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W:0]    prog_len;
  logic               busy;
  logic               done;

  modport master (
    output load_valid, load_data, clear, start, stall,
    input  load_ready, instruction, instr_valid, pc, prog_len, busy, done
  );

  modport slave (
    input  load_valid, load_data, clear, start, stall,
    output load_ready, instruction, instr_valid, pc, prog_len, busy, done
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Holds a host-loaded program and issues one word per non-stalled cycle on a
// registered bus to control_unit; the bus carries all-zero NOP otherwise.
module instruction_sequencer #(
  parameter int INSTR_W = 88,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6
) (
  input logic clk,
  input logic rst,
  instruction_sequencer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];

  state_t             state, state_n;
  logic [INSTR_W-1:0] instr_q, instr_n;
  logic               valid_q, valid_n;
  logic               done_q, done_n;
  logic [ADDR_W-1:0]  pc_q, pc_n;
  logic [ADDR_W:0]    len_q, len_n;
  logic               wr_en;
  logic               load_ready;

  assign load_ready = (state == IDLE) && !bus.clear && !bus.start && (len_q < FULL);

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    len_n   = len_q;
    instr_n = '0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          len_n = '0;
        end else if (bus.start) begin
          if (len_q != '0) begin
            state_n = RUN;
            pc_n    = '0;
          end
        end else if (bus.load_valid && load_ready) begin
          wr_en = 1'b1;
          len_n = len_q + 1'b1;
        end
      end
      RUN: begin
        // Asynchronous read of mem[pc] so word k lands on the bus at E+1+k.
        if (!bus.stall) begin
          instr_n = mem[pc_q];
          valid_n = 1'b1;
          if (({1'b0, pc_q} + 1'b1) == len_q) begin
            done_n  = 1'b1;
            state_n = IDLE;
            pc_n    = '0;
          end else begin
            pc_n = pc_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
      len_q   <= '0;
    end else begin
      state   <= state_n;
      instr_q <= instr_n;
      valid_q <= valid_n;
      done_q  <= done_n;
      pc_q    <= pc_n;
      len_q   <= len_n;
    end
  end

  // Storage is not reset; entries at or beyond prog_len are never read.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[len_q[ADDR_W-1:0]] <= bus.load_data;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.done        = done_q;
  assign bus.pc          = pc_q;
  assign bus.prog_len    = len_q;
  assign bus.busy        = (state == RUN);
endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: a queue-based program model
// predicts issued words; a negedge monitor pops and compares every bus cycle.
module tb_instruction_sequencer;
  localparam int W  = 88;
  localparam int D  = 64;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_sequencer_if #(.INSTR_W(W), .DEPTH(D), .ADDR_W(AW)) bus ();

  instruction_sequencer #(.INSTR_W(W), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [W-1:0] word;
    bit           last;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] prog[$];
  int           total = 0;
  int           bad   = 0;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    if (t[W-1:0] == '0) t[0] = 1'b1;
    return t[W-1:0];
  endfunction

  // Monitor: every cycle either a predicted word or a clean NOP.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.instr_valid === 1'b1) begin
        exp_t e;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got %0h want no issue", bus.instruction);
        end else begin
          e = sb.pop_front();
          check("issue_word", bus.instruction, e.word);
          check("issue_done", bus.done, e.last);
        end
      end else begin
        check("nop_valid", bus.instr_valid, 0);
        check("nop_word", bus.instruction, 0);
        check("nop_done", bus.done, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.clear      = 1'b0;
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
  endtask

  task automatic offer(input logic [W-1:0] w);
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    @(negedge clk);
    check("load_ready", bus.load_ready, prog.size() < D);
    check("prog_len", bus.prog_len, prog.size());
    @(posedge clk);
    if (prog.size() < D) prog.push_back(w);
    #1 bus.load_valid = 1'b0;
  endtask

  task automatic clear_prog();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    prog.delete();
  endtask

  task automatic run(input bit rnd, input logic [127:0] pat, input bit noise);
    int n   = 0;
    int len = prog.size();
    bit s;
    bit fin = 1'b0;
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.word = prog[i];
      e.last = (i == len - 1);
      sb.push_back(e);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      s = rnd ? ($urandom_range(0, 3) == 0) : (c < 128 ? pat[c] : 1'b0);
      bus.stall = s;
      if (noise) begin
        bus.start      = 1'($urandom_range(0, 1));
        bus.clear      = 1'($urandom_range(0, 1));
        bus.load_valid = 1'b1;
        bus.load_data  = rnd_word();
        #1 check("run_load_ready", bus.load_ready, 0);
      end
      @(posedge clk);
      if (!s) n++;
      @(negedge clk);
      check("run_pc", bus.pc, (n == len) ? 0 : n);
      check("run_busy", bus.busy, n < len);
      if (n == len) begin
        fin = 1'b1;
        idle_inputs();
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got %0d issued want %0d", n, len);
    end
    idle_inputs();
    tick();
    tick();
    check("sb_drained", sb.size(), 0);
    check("post_run_len", bus.prog_len, prog.size());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_pc", bus.pc, 0);
    check("rst_len", bus.prog_len, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_load_ready", bus.load_ready, 1);
    tick();

    // load A, B, C and run straight through
    offer(88'h0A_1111_2222_3333_4444_5555);
    offer(88'h0B_6666_7777_8888_9999_AAAA);
    offer(88'h0C_BBBB_CCCC_DDDD_EEEE_FFFF);
    run(1'b0, '0, 1'b0);
    // single stall on the cycle after A is issued
    run(1'b0, 128'b10, 1'b0);
    // append D, rerun with start/clear/load noise during RUN
    offer(88'h0D_0123_4567_89AB_CDEF_0011);
    run(1'b0, '0, 1'b1);

    // reset mid-run after two words
    sb.push_back('{word: prog[0], last: 1'b0});
    sb.push_back('{word: prog[1], last: 1'b0});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    prog.delete();
    @(negedge clk);
    check("abort_len", bus.prog_len, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_pc", bus.pc, 0);
    check("abort_load_ready", bus.load_ready, 1);
    check("abort_sb", sb.size(), 0);
    tick();

    // clear beats start beats load; then start with empty program
    offer(rnd_word());
    offer(rnd_word());
    bus.clear      = 1'b1;
    bus.start      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = rnd_word();
    #1 check("prio_load_ready", bus.load_ready, 0);
    tick();
    idle_inputs();
    prog.delete();
    @(negedge clk);
    check("prio_len", bus.prog_len, 0);
    check("prio_busy", bus.busy, 0);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_start_busy", bus.busy, 0);
      check("empty_start_done", bus.done, 0);
    end
    tick();

    // overfill: 70 offers, 64 kept
    for (int i = 0; i < 70; i++) offer(rnd_word());
    @(negedge clk);
    check("full_len", bus.prog_len, D);
    check("full_load_ready", bus.load_ready, 0);
    tick();
    run(1'b1, '0, 1'b0);

    // randomized load/run rounds
    for (int r = 0; r < 8; r++) begin
      int nw;
      if ($urandom_range(0, 1) == 1 || prog.size() == 0) clear_prog();
      nw = $urandom_range(1, 8);
      for (int i = 0; i < nw; i++) offer(rnd_word());
      run(1'b1, '0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
